// File: rtl/conv_pkg.sv
// Shared widths for the 8-to-32 deserializer and its 32-to-8 serializer twin.
package conv_pkg;

    localparam int W      = 8;
    localparam int N      = 4;
    localparam int WORD_W = W * N;
    localparam int CNT_W  = $clog2(N);

    // The accumulator only ever needs the first N-1 bytes of a group.
    localparam int ACC_W  = W * (N - 1);

endpackage

// File: rtl/conv8_32.sv
// Byte-to-word deserializer: packs N valid bytes (MSB first) into one word held N cycles.
// Optional macro CONV8_32_ERR_EN adds err_frag, a one-cycle pulse when a partial group is dropped.
module conv8_32
    import conv_pkg::*;
(
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [W-1:0]      in_data8,
    input  logic              in8,
    output logic [WORD_W-1:0] out_data32,
    output logic              out32
`ifdef CONV8_32_ERR_EN
    ,
    output logic              err_frag
`endif
);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  hold;
    logic [ACC_W-1:0]  acc;
    logic [WORD_W-1:0] shifted;
    logic              complete;

    assign shifted  = {acc, in_data8};
    assign complete = in8 && (cnt == CNT_W'(N - 1));

    // A gap in in8 restarts the group, so cnt==0 always marks a word boundary.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            cnt <= '0;
            acc <= '0;
        end else if (in8) begin
            cnt <= cnt + CNT_W'(1);
            acc <= shifted[ACC_W-1:0];
        end else begin
            cnt <= '0;
            acc <= '0;
        end
    end

    // A fresh completion always wins over hold expiry, keeping out32 high on a steady stream.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            hold       <= '0;
            out32      <= 1'b0;
            out_data32 <= '0;
        end else if (complete) begin
            hold       <= CNT_W'(N - 1);
            out32      <= 1'b1;
            out_data32 <= shifted;
        end else if (hold != '0) begin
            hold       <= hold - CNT_W'(1);
        end else begin
            out32      <= 1'b0;
            out_data32 <= '0;
        end
    end

`ifdef CONV8_32_ERR_EN
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            err_frag <= 1'b0;
        end else begin
            err_frag <= !in8 && (cnt != '0);
        end
    end
`endif

endmodule

// File: tb/tb_conv8_32.sv
// Self-checking bench for conv8_32: vector table, corner-case sequences, random stream vs. a queue model.
// Build with +define+CONV8_32_ERR_EN to also check err_frag.
module tb_conv8_32;
    import conv_pkg::*;

    logic              clk_4f;
    logic              reset;
    logic [W-1:0]      in_data8;
    logic              in8;
    logic [WORD_W-1:0] out_data32;
    logic              out32;
`ifdef CONV8_32_ERR_EN
    logic              err_frag;
`endif

    conv8_32 dut (
        .clk_4f     (clk_4f),
        .reset      (reset),
        .in_data8   (in_data8),
        .in8        (in8),
        .out_data32 (out_data32),
        .out32      (out32)
`ifdef CONV8_32_ERR_EN
        ,
        .err_frag   (err_frag)
`endif
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    int passCount  = 0;
    int checkCount = 0;

    // Reference model: bytes of the current group in a queue, plus how many more
    // cycles the last completed word remains visible.
    logic [W-1:0]      grp[$];
    logic [WORD_W-1:0] modelWord = '0;
    int                modelLeft = 0;
    logic              modelErr  = 1'b0;

    function automatic void modelStep(input logic rst, input logic v, input logic [W-1:0] d);
        logic [WORD_W-1:0] w;
        if (rst) begin
            grp.delete();
            modelWord = '0;
            modelLeft = 0;
            modelErr  = 1'b0;
            return;
        end
        modelErr = !v && (grp.size() != 0);
        if (v) begin
            grp.push_back(d);
            if (grp.size() == N) begin
                w = '0;
                foreach (grp[i]) w = (w << W) | WORD_W'(grp[i]);
                modelWord = w;
                modelLeft = N;
                grp.delete();
                return;
            end
        end else begin
            grp.delete();
        end
        if (modelLeft > 0) modelLeft--;
    endfunction

    task automatic applyStimulus(input logic rst, input logic v, input logic [W-1:0] d);
        reset    = rst;
        in8      = v;
        in_data8 = d;
        @(posedge clk_4f);
        #1;
        modelStep(rst, v, d);
    endtask

    task automatic checkOutput(input string name, input logic expValid, input logic [WORD_W-1:0] expData);
        checkCount++;
        if (out32 === expValid && out_data32 === expData) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got out32=%b out_data32=%h, expected out32=%b out_data32=%h",
                     name, out32, out_data32, expValid, expData);
        end
    endtask

    task automatic checkErr(input string name, input logic expErr);
`ifdef CONV8_32_ERR_EN
        checkCount++;
        if (err_frag === expErr) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got err_frag=%b, expected %b", name, err_frag, expErr);
        end
`else
        if (expErr === 1'bx) $display("[TB] unreachable %s", name);
`endif
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, modelLeft > 0, (modelLeft > 0) ? modelWord : '0);
        checkErr({name, "_err"}, modelErr);
    endtask

    typedef struct {
        logic              rst;
        logic              v;
        logic [W-1:0]      d;
        logic              expValid;
        logic [WORD_W-1:0] expData;
        string             name;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input logic rst, input logic v, input logic [W-1:0] d,
                                   input logic ev, input logic [WORD_W-1:0] ed, input string name);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.expValid = ev; r.expData = ed; r.name = name;
        vecs.push_back(r);
    endfunction

    initial begin
        reset    = 1'b1;
        in8      = 1'b0;
        in_data8 = '0;

        // Reset held with live data, then the first idle cycle after release.
        addVec(1, 1, 8'h5A, 0, 32'h0, "reset0");
        addVec(1, 1, 8'hC3, 0, 32'h0, "reset1");
        addVec(1, 1, 8'h7E, 0, 32'h0, "reset2");
        addVec(0, 0, 8'h00, 0, 32'h0, "post_reset");
        // Single word followed by a gap: visible for exactly 4 cycles.
        addVec(0, 1, 8'hDE, 0, 32'h0,        "single_b0");
        addVec(0, 1, 8'hAD, 0, 32'h0,        "single_b1");
        addVec(0, 1, 8'hBE, 0, 32'h0,        "single_b2");
        addVec(0, 1, 8'hEF, 1, 32'hDEADBEEF, "single_h0");
        addVec(0, 0, 8'h00, 1, 32'hDEADBEEF, "single_h1");
        addVec(0, 0, 8'h00, 1, 32'hDEADBEEF, "single_h2");
        addVec(0, 0, 8'h00, 1, 32'hDEADBEEF, "single_h3");
        addVec(0, 0, 8'h00, 0, 32'h0,        "single_expire");
        addVec(0, 0, 8'h00, 0, 32'h0,        "single_idle");
        // Back-to-back words: out32 never drops between them.
        addVec(0, 1, 8'h01, 0, 32'h0,        "b2b_01");
        addVec(0, 1, 8'h02, 0, 32'h0,        "b2b_02");
        addVec(0, 1, 8'h03, 0, 32'h0,        "b2b_03");
        addVec(0, 1, 8'h04, 1, 32'h01020304, "b2b_04");
        addVec(0, 1, 8'h05, 1, 32'h01020304, "b2b_05");
        addVec(0, 1, 8'h06, 1, 32'h01020304, "b2b_06");
        addVec(0, 1, 8'h07, 1, 32'h01020304, "b2b_07");
        addVec(0, 1, 8'h08, 1, 32'h05060708, "b2b_08");
        addVec(0, 0, 8'h00, 1, 32'h05060708, "b2b_h1");
        addVec(0, 0, 8'h00, 1, 32'h05060708, "b2b_h2");
        addVec(0, 0, 8'h00, 1, 32'h05060708, "b2b_h3");
        addVec(0, 0, 8'h00, 0, 32'h0,        "b2b_expire");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].d);
            checkOutput(vecs[i].name, vecs[i].expValid, vecs[i].expData);
        end

        // Fragment: AA BB, one-cycle gap, then a full group.
        applyStimulus(0, 1, 8'hAA); checkModel("frag_aa");
        applyStimulus(0, 1, 8'hBB); checkModel("frag_bb");
        applyStimulus(0, 0, 8'h00); checkOutput("frag_gap", 0, 32'h0);
        checkErr("frag_err_pulse", 1'b1);
        applyStimulus(0, 1, 8'h11); checkOutput("frag_11", 0, 32'h0);
        checkErr("frag_err_clear", 1'b0);
        applyStimulus(0, 1, 8'h22); checkModel("frag_22");
        applyStimulus(0, 1, 8'h33); checkOutput("frag_33", 0, 32'h0);
        applyStimulus(0, 1, 8'h44); checkOutput("frag_word", 1, 32'h11223344);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 8'h00); checkModel("frag_tail");
        end

        // Reset on the second hold cycle, then a clean word.
        applyStimulus(0, 1, 8'hCA); applyStimulus(0, 1, 8'hFE); applyStimulus(0, 1, 8'hF0);
        applyStimulus(0, 1, 8'h0D); checkOutput("hold_word", 1, 32'hCAFEF00D);
        applyStimulus(0, 0, 8'h00); checkOutput("hold_cycle2", 1, 32'hCAFEF00D);
        applyStimulus(1, 0, 8'h00); checkOutput("hold_reset", 0, 32'h0);
        applyStimulus(0, 1, 8'h13); applyStimulus(0, 1, 8'h57); applyStimulus(0, 1, 8'h9B);
        checkOutput("hold_after_b2", 0, 32'h0);
        applyStimulus(0, 1, 8'hDF); checkOutput("hold_next_word", 1, 32'h13579BDF);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00);
        checkOutput("hold_next_expire", 0, 32'h0);

        // Reset mid-group discards the partial bytes.
        applyStimulus(0, 1, 8'h12); applyStimulus(0, 1, 8'h34);
        applyStimulus(1, 1, 8'h99); checkModel("midgrp_reset");
        applyStimulus(0, 1, 8'h56); applyStimulus(0, 1, 8'h78);
        applyStimulus(0, 1, 8'h9A); checkOutput("midgrp_b2", 0, 32'h0);
        applyStimulus(0, 1, 8'hBC); checkOutput("midgrp_word", 1, 32'h56789ABC);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00);
        checkOutput("midgrp_h3", 1, 32'h56789ABC);

        // Random stream against the queue model.
        for (int i = 0; i < 600; i++) begin
            logic rst;
            logic v;
            rst = ($urandom_range(0, 99) < 2);
            v   = ($urandom_range(0, 99) < 85);
            applyStimulus(rst, v, W'($urandom));
            checkModel("random");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/conv8_32.md
Name: conv8_32

Overview:
- Byte-to-word deserializer. Receives an MSB-first byte stream at clk_4f and assembles each group of 4 consecutive valid bytes into one 32-bit word.
- Sits on the receive side of the byte link and feeds the word-rate (clk_f) logic.
- Mirror of the 32-to-8 serializer: byte 0 of a group maps to word bits [31:24], byte 3 to bits [7:0].
- Each word is held stable for 4 clk_4f cycles, i.e. one clk_f period.

Parameters:
- W, 8, byte width.
- N, 4, bytes per word. Must be a power of 2 and >= 2. Output width is W*N.

Ports:
- clk_4f  in  1  byte-rate clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- in_data8  in  W  incoming byte; sampled only when in8=1.
- in8  in  1  input byte valid.
- out_data32  out  W*N  assembled word; MSB byte is the first byte received.
- out32  out  1  output word valid.

Behaviour:
- Reset (sampled at clk_4f edge with reset=1): cnt=0, acc=0, hold=0, out_data32=0, out32=0. Reset dominates every other event.
- Byte counter cnt[$clog2(N)-1:0]:
  - in8=1: increments, wrapping N-1 -> 0.
  - in8=0: forced to 0 and the partial word in acc is discarded.
- Accumulator: on in8=1, acc <= {acc[W*(N-1)-1:0], in_data8}.
- Word completion, on in8=1 with cnt==N-1:
  - out_data32 <= {acc[W*(N-1)-1:0], in_data8};
  - out32 <= 1;
  - hold <= N-1.
- Latency: a word is visible on out_data32/out32 at the edge that samples its last byte, i.e. 1 cycle after the last byte is presented.
- Hold timer: hold[$clog2(N)-1:0] decrements each cycle while nonzero and no new word completes.
  - When hold==0 and no completion this cycle: out32 <= 0, out_data32 <= 0.
- Continuous stream: a new word completes exactly N cycles after the previous one, so out32 stays high continuously. out_data32 changes only at completion edges.
- in8 drops mid-group (cnt!=0): partial bytes are lost. The next group starts fresh at cnt=0 when in8 reasserts. A word already on the output still completes its N-cycle hold.
- in8 drops at a group boundary (cnt==0): no loss. The output hold expires normally.
- Reset mid-group or mid-hold: everything is cleared at that edge. No word is emitted for the interrupted group.
- Completion and hold expiry in the same cycle: completion wins, and out32 stays 1.
- out_data32 is 0 whenever out32=0.
- No back-pressure; the consumer must accept every word.

Optional Feature:
- Macro: CONV8_32_ERR_EN.
- Defined: adds output port err_frag (1 bit). It is registered and pulses 1 for exactly one cycle, the cycle after an edge where in8=0 and cnt!=0 (fragment discarded). It is 0 in reset and also cleared by reset.
- Undefined: the port does not exist and fragments are dropped silently. All other behaviour is identical.

Decomposition:
- Shared package conv_pkg holds:
  - W (8) and N (4);
  - derived WORD_W = W*N and CNT_W = $clog2(N), shared with the 32-to-8 serializer.
- Single module, no sub-module: counter, accumulator, hold timer and output register are tightly coupled.

Test Plan:
- Reset: assert reset for 3 cycles with in8=1 and random data -> out32=0, out_data32=0 throughout and on the first cycle after release.
- Single word: bytes 0xDE,0xAD,0xBE,0xEF on 4 consecutive cycles, then in8=0 -> out_data32=0xDEADBEEF with out32=1 for exactly 4 cycles starting 1 cycle after 0xEF, then 0.
- Back-to-back: bytes 0x01..0x08 continuous -> 0x01020304 for 4 cycles, then 0x05060708 for 4 cycles, with out32 never dropping between them.
- Fragment: bytes 0xAA,0xBB, then in8=0 for 1 cycle, then 0x11,0x22,0x33,0x44 -> only 0x11223344 is emitted; with CONV8_32_ERR_EN, err_frag pulses once, one cycle after the gap.
- Reset mid-hold: reset on the 2nd hold cycle of 0xCAFEF00D -> out32=0 and out_data32=0 on the next edge; the next 4 bytes form a correct word.
- Reset mid-group: 0x12,0x34, reset, then 0x56,0x78,0x9A,0xBC -> only 0x56789ABC is emitted.
